// File: rtl/seg7_capture.sv
// Reads back a multiplexed, active-low seven-segment bus and waits until each digit holds steady.
// It decodes each digit to a hex nibble and publishes a full frame once every digit has been seen.
module seg7_capture #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [7:0]              seg_in,
  input  logic [NUM_DIGITS-1:0]   an_in,
  output logic [4*NUM_DIGITS-1:0] value_out,
  output logic [NUM_DIGITS-1:0]   dp_out,
  output logic [NUM_DIGITS-1:0]   err_out,
  output logic                    digit_strobe,
  output logic                    frame_valid
);
  typedef enum logic [1:0] {WAIT, COUNT, HELD} state_t;

  localparam logic [7:0] STABLE = 8'(STABLE_CYCLES);

  state_t                  state, state_nx;
  logic [7:0]              cnt, cnt_nx;
  logic [NUM_DIGITS-1:0]   s_an, p_an, sel, captured;
  logic [7:0]              s_seg, p_seg;
  logic                    s_valid, s_same, accept, restart, frame_done, nib_ok;
  logic [3:0]              nib;
  logic [4*NUM_DIGITS-1:0] sh_val;
  logic [NUM_DIGITS-1:0]   sh_dp, sh_err;

  // A sample is valid when exactly one anode is driven low.
  assign sel        = ~s_an;
  assign s_valid    = (sel != '0) && ((sel & (sel - NUM_DIGITS'(1))) == '0);
  assign s_same     = (s_an == p_an) && (s_seg == p_seg);
  assign frame_done = &captured;

  always_comb begin
    nib    = 4'd0;
    nib_ok = 1'b1;
    case (s_seg[6:0])
      7'h40: nib = 4'h0;
      7'h79: nib = 4'h1;
      7'h24: nib = 4'h2;
      7'h30: nib = 4'h3;
      7'h19: nib = 4'h4;
      7'h12: nib = 4'h5;
      7'h02: nib = 4'h6;
      7'h78: nib = 4'h7;
      7'h00: nib = 4'h8;
      7'h18: nib = 4'h9;
      7'h08: nib = 4'hA;
      7'h03: nib = 4'hB;
      7'h46: nib = 4'hC;
      7'h21: nib = 4'hD;
      7'h06: nib = 4'hE;
      7'h0E: nib = 4'hF;
      default: nib_ok = 1'b0;
    endcase
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    accept   = 1'b0;
    restart  = 1'b0;
    if (!s_valid) begin
      state_nx = WAIT;
      cnt_nx   = 8'd0;
    end else begin
      case (state)
        WAIT:  restart = 1'b1;
        COUNT: begin
          if (s_same) begin
            cnt_nx = cnt + 8'd1;
            if (cnt_nx == STABLE) begin
              accept   = 1'b1;
              state_nx = HELD;
            end
          end else begin
            restart = 1'b1;
          end
        end
        HELD:    restart = !s_same;
        default: state_nx = WAIT;
      endcase
      // A fresh pattern starts a new dwell; with a one-cycle dwell it is accepted at once.
      if (restart) begin
        cnt_nx = 8'd1;
        if (STABLE == 8'd1) begin
          accept   = 1'b1;
          state_nx = HELD;
        end else begin
          state_nx = COUNT;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_an         <= '1;
      p_an         <= '1;
      s_seg        <= 8'hFF;
      p_seg        <= 8'hFF;
      state        <= WAIT;
      cnt          <= 8'd0;
      captured     <= '0;
      sh_val       <= '0;
      sh_dp        <= '0;
      sh_err       <= '0;
      value_out    <= '0;
      dp_out       <= '0;
      err_out      <= '0;
      digit_strobe <= 1'b0;
      frame_valid  <= 1'b0;
    end else begin
      s_an         <= an_in;
      s_seg        <= seg_in;
      p_an         <= s_an;
      p_seg        <= s_seg;
      state        <= state_nx;
      cnt          <= cnt_nx;
      digit_strobe <= accept;
      frame_valid  <= frame_done;
      if (frame_done) begin
        value_out <= sh_val;
        dp_out    <= sh_dp;
        err_out   <= sh_err;
      end
      // The clear for a completed frame happens first, so a same-cycle accept lands in the next frame.
      captured <= (frame_done ? '0 : captured) | (accept ? sel : '0);
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (accept && sel[i]) begin
          sh_val[4*i +: 4] <= nib_ok ? nib : 4'd0;
          sh_err[i]        <= !nib_ok;
          sh_dp[i]         <= ~s_seg[7];
        end
      end
    end
  end
endmodule
